// File: rtl/bf_pkg.sv
// ============================================================================
// Module      : bf_pkg
// Description : Shared constants, word layouts and FSM encoding for the
//               Bellman-Ford relax pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bf_pkg;

  localparam int LANES  = 4;
  localparam int ADDR_W = 6;
  localparam int NODE_W = 5;
  localparam int WGT_W  = 8;

  // Edge word, LSB first: {wj, wi, j, i, wij, up}
  localparam int EW_UP  = 0;
  localparam int EW_WIJ = 1;
  localparam int EW_I   = EW_WIJ + WGT_W;
  localparam int EW_J   = EW_I + NODE_W;
  localparam int EW_WI  = EW_J + NODE_W;
  localparam int EW_WJ  = EW_WI + WGT_W;
  localparam int EDGE_W = EW_WJ + WGT_W;

  // Forward word, LSB first: {dist, j, up}
  localparam int FW_UP   = 0;
  localparam int FW_J    = 1;
  localparam int FW_DIST = FW_J + NODE_W;
  localparam int FWD_W   = FW_DIST + WGT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bf_inflight_cnt.sv
// ============================================================================
// Module      : bf_inflight_cnt
// Description : Up/down count of issued-but-unretired groups with a sticky
//               underflow error flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bf_inflight_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_inc && !i_dec)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (!i_inc && i_dec && (r_cnt != '0))
        r_cnt <= r_cnt - CNT_W'(1);
      // A retirement with nothing outstanding cannot be legitimate
      if (i_dec && (r_cnt == '0))
        r_err <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

`default_nettype wire

// File: rtl/bf_pass_scheduler.sv
// ============================================================================
// Module      : bf_pass_scheduler
// Description : Issues edge-group passes until convergence or the pass limit,
//               then one detection pass to flag a negative cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bf_pass_scheduler
  import bf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_grp,
  input  logic [NODE_W:0]   i_num_nodes,
  input  logic              i_stall,
  input  logic              i_wb_valid,
  input  logic [LANES-1:0]  i_wb_upd,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_pass_start,
  output logic [NODE_W:0]   o_pass_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_converged,
  output logic              o_neg_cycle,
  output logic              o_err
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_ngrp;
  logic [NODE_W:0]   r_nnodes, r_pass_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pass_start, r_pass_upd, r_done, r_conv, r_neg;
  logic              w_rd_en, w_last, w_accept, w_degen;
  logic              w_launch, w_finish, w_neg;
  logic [ADDR_W:0]   w_inflight;

  assign w_rd_en  = (r_state == ST_ISSUE) && !i_stall;
  assign w_last   = (({1'b0, r_addr} + (ADDR_W+1)'(1)) == r_ngrp);
  assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_degen  = (i_num_grp == '0) || (i_num_nodes <= (NODE_W+1)'(1));

  bf_inflight_cnt #(.CNT_W(ADDR_W+1)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_en),
    .i_dec (i_wb_valid),
    .o_cnt (w_inflight),
    .o_err (o_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    w_neg       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_degen) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_launch    = 1'b1;
          end
        end
      end
      ST_ISSUE: if (w_rd_en && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_inflight == '0) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        // pass_cnt == num_nodes means the detection pass just finished
        if (!r_pass_upd) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end else if (r_pass_cnt < r_nnodes) begin
          w_state_nxt = ST_ISSUE;
          w_launch    = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
          w_neg       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ngrp       <= '0;
      r_nnodes     <= '0;
      r_pass_cnt   <= '0;
      r_addr       <= '0;
      r_pass_start <= 1'b0;
      r_pass_upd   <= 1'b0;
      r_done       <= 1'b0;
      r_conv       <= 1'b0;
      r_neg        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pass_start <= w_launch;
      if (w_accept) begin
        r_ngrp     <= i_num_grp;
        r_nnodes   <= i_num_nodes;
        r_pass_cnt <= '0;
        r_addr     <= '0;
        r_done     <= 1'b0;
        r_conv     <= 1'b0;
        r_neg      <= 1'b0;
      end
      if (w_launch)
        r_pass_cnt <= w_accept ? (NODE_W+1)'(1) : r_pass_cnt + (NODE_W+1)'(1);
      if (w_launch)
        r_pass_upd <= 1'b0;
      else if (i_wb_valid)
        r_pass_upd <= r_pass_upd | (|i_wb_upd);
      if (w_rd_en)
        r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
      if (w_finish) begin
        r_done <= 1'b1;
        r_conv <= !w_neg;
        r_neg  <= w_neg;
      end
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_addr;
  assign o_pass_start = r_pass_start;
  assign o_pass_cnt   = r_pass_cnt;
  assign o_busy       = (r_state == ST_ISSUE) || (r_state == ST_DRAIN) || (r_state == ST_CHECK);
  assign o_done       = r_done;
  assign o_converged  = r_conv;
  assign o_neg_cycle  = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_bf_pass_scheduler.sv
// ============================================================================
// Module      : tb_bf_pass_scheduler
// Description : Randomised scoreboard bench for bf_pass_scheduler.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bf_pass_scheduler;
  import bf_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [ADDR_W:0]   i_num_grp = '0;
  logic [NODE_W:0]   i_num_nodes = '0;
  logic              i_stall = 1'b0;
  logic              i_wb_valid = 1'b0;
  logic [LANES-1:0]  i_wb_upd = '0;
  logic              o_rd_en, o_pass_start, o_busy, o_done, o_converged, o_neg_cycle, o_err;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [NODE_W:0]   o_pass_cnt;

  bf_pass_scheduler dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_grp(i_num_grp),
    .i_num_nodes(i_num_nodes), .i_stall(i_stall), .i_wb_valid(i_wb_valid),
    .i_wb_upd(i_wb_upd), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_pass_start(o_pass_start), .o_pass_cnt(o_pass_cnt), .o_busy(o_busy),
    .o_done(o_done), .o_converged(o_converged), .o_neg_cycle(o_neg_cycle),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass_cnt;
    bit conv;
    bit neg;
    int issues;
  } res_t;

  int          checks = 0;
  int          failures = 0;
  int          exp_addr_q[$];
  res_t        exp_res_q[$];
  int          due_q[$];
  logic [3:0]  upd_q[$];
  int          last_due = 0;
  int          cyc = 0;
  int          issue_k = 0;
  int          cur_ng = 0;
  logic [31:0] cur_plan = '0;
  int          stall_pct = 0;
  bit          force_wb = 1'b0;
  bit          armed = 1'b0;
  int          run_issues = 0;
  int          run_starts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flush();
    exp_addr_q.delete();
    exp_res_q.delete();
    due_q.delete();
    upd_q.delete();
    last_due = 0;
    issue_k  = 0;
    armed    = 1'b0;
  endtask

  // Input driver: stall pattern and write-back returns, changed 2ns after the edge
  initial forever begin
    @(posedge clk);
    #2;
    i_stall = (stall_pct > 0) && (int'($urandom_range(0, 99)) < stall_pct);
    if (force_wb) begin
      i_wb_valid = 1'b1;
      i_wb_upd   = '0;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      i_wb_valid = 1'b1;
      i_wb_upd   = upd_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      i_wb_valid = 1'b0;
      i_wb_upd   = '0;
    end
  end

  // Pipeline model: every issued group retires after a random latency
  initial begin
    int lat, d, p, g;
    forever begin
      @(negedge clk);
      if (!rst && o_rd_en) begin
        lat = int'($urandom_range(1, 5));
        d   = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        p = (cur_ng > 0) ? issue_k / cur_ng + 1 : 0;
        g = (cur_ng > 0) ? issue_k % cur_ng : 0;
        issue_k++;
        due_q.push_back(d);
        if (p < 32 && cur_plan[p] && g == (p % cur_ng))
          upd_q.push_back(4'($urandom_range(1, 15)));
        else
          upd_q.push_back(4'b0);
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (o_rd_en) begin
        run_issues++;
        chk("issue_under_stall", {31'b0, i_stall}, 32'd0);
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: got rd_addr %0d expected no issue", o_rd_addr);
        end else begin
          chk("rd_addr", {26'b0, o_rd_addr}, exp_addr_q.pop_front());
        end
      end
      if (o_pass_start) run_starts++;
      if (armed && !i_start && o_done) begin
        armed = 1'b0;
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          r = exp_res_q.pop_front();
          chk("pass_cnt",    {26'b0, o_pass_cnt}, r.pass_cnt);
          chk("converged",   {31'b0, o_converged}, {31'b0, r.conv});
          chk("neg_cycle",   {31'b0, o_neg_cycle}, {31'b0, r.neg});
          chk("issue_total", run_issues, r.issues);
          chk("pass_starts", run_starts, r.pass_cnt);
          chk("addr_left",   exp_addr_q.size(), 32'd0);
          chk("err_clean",   {31'b0, o_err}, 32'd0);
        end
      end
      if (i_start && !o_busy) begin
        armed      = 1'b1;
        run_issues = 0;
        run_starts = 0;
      end
    end
  end

  task automatic run(input int ng, input int nn, input logic [31:0] plan,
                     input int spct, input bit poke);
    res_t r;
    int   p;
    cur_ng   = ng;
    cur_plan = plan;
    issue_k  = 0;
    r.conv = 1'b1;
    r.neg  = 1'b0;
    r.pass_cnt = 0;
    if (ng > 0 && nn > 1) begin
      p = 0;
      while (1) begin
        p++;
        if (!plan[p]) break;
        if (p == nn) begin
          r.conv = 1'b0;
          r.neg  = 1'b1;
          break;
        end
      end
      r.pass_cnt = p;
    end
    r.issues = r.pass_cnt * ng;
    for (int k = 0; k < r.pass_cnt; k++)
      for (int g = 0; g < ng; g++)
        exp_addr_q.push_back(g);
    exp_res_q.push_back(r);

    @(posedge clk); #2;
    stall_pct   = spct;
    i_num_grp   = (ADDR_W+1)'(ng);
    i_num_nodes = (NODE_W+1)'(nn);
    i_start     = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #2;
      if (o_busy) begin
        i_num_grp   = (ADDR_W+1)'(ng + 1);
        i_num_nodes = (NODE_W+1)'(nn + 1);
        i_start     = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
      end
    end
    for (int t = 0; t < 4000 && exp_res_q.size() > 0; t++) @(negedge clk);
    if (exp_res_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: got no done expected done (ng=%0d nn=%0d)", ng, nn);
      flush();
    end
    stall_pct = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en",  {31'b0, o_rd_en}, 32'd0);
    chk("rst_busy",   {31'b0, o_busy}, 32'd0);
    chk("rst_done",   {31'b0, o_done}, 32'd0);
    chk("rst_pcnt",   {26'b0, o_pass_cnt}, 32'd0);
    chk("rst_err",    {31'b0, o_err}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    run(3, 4, 32'h0, 0, 1'b0);
    run(3, 4, 32'b0010, 0, 1'b0);
    run(3, 4, 32'hFFFF_FFFF, 0, 1'b0);
    run(3, 4, 32'hFFFF_FFFF, 40, 1'b1);
    run(0, 4, 32'hFFFF_FFFF, 0, 1'b0);
    run(5, 1, 32'hFFFF_FFFF, 0, 1'b0);
    run(6, 2, 32'hFFFF_FFFF, 30, 1'b0);
    for (int n = 0; n < 14; n++)
      run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom,
          int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));

    // Degenerate run, then a write-back with nothing in flight
    run(0, 3, 32'h0, 0, 1'b0);
    @(posedge clk); #2;
    force_wb = 1'b1;
    @(posedge clk); #2;
    force_wb = 1'b0;
    @(negedge clk);
    chk("err_set", {31'b0, o_err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'b0, o_err}, 32'd1);

    // Abort mid-pass with reset
    cur_ng   = 6;
    cur_plan = 32'hFFFF_FFFF;
    issue_k  = 0;
    for (int g = 0; g < 6; g++) exp_addr_q.push_back(g);
    @(posedge clk); #2;
    i_num_grp   = 7'd6;
    i_num_nodes = 6'd4;
    i_start     = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        @(negedge clk);
        seen = o_rd_en && (o_rd_addr == 6'd2);
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL abort_wait: got no issue at addr 2 expected one");
      end
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_rd_en", {31'b0, o_rd_en}, 32'd0);
    chk("abort_addr",  {26'b0, o_rd_addr}, 32'd0);
    chk("abort_busy",  {31'b0, o_busy}, 32'd0);
    chk("abort_pcnt",  {26'b0, o_pass_cnt}, 32'd0);
    chk("abort_err",   {31'b0, o_err}, 32'd0);
    chk("abort_pst",   {31'b0, o_pass_start}, 32'd0);
    flush();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("release_rd_en", {31'b0, o_rd_en}, 32'd0);

    run(4, 3, 32'b0010, 0, 1'b0);
    run(5, 5, 32'hFFFF_FFFF, 20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
